// File: rtl/war_pkg.sv
// Shared definitions for the card-RAM arbiter and everything that talks to
// the ram_controller: op encodings, data/address widths, requester indices.
package war_pkg;

    localparam int WAR_ADDR_W = 10;
    localparam int WAR_DATA_W = 16;

    localparam int REQ_GAME = 0;
    localparam int REQ_DRAW = 1;
    localparam int REQ_SHUF = 2;

    typedef enum logic [1:0] {
        RAM_OP_INIT    = 2'd0,
        RAM_OP_READ    = 2'd1,
        RAM_OP_STORE   = 2'd2,
        RAM_OP_SHUFFLE = 2'd3
    } ram_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: finds the first set request bit starting just after
// last_grant and wrapping modulo NUM_REQ.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               any,
    output logic [IDX_W-1:0]   index
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        any      = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand     = (int'(last_grant) + off) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                any   = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing one card-RAM controller among NUM_REQ requesters.
// One op at a time, round-robin grants, watchdog abort on a stuck op.
module ram_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int OP_W        = 2,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*OP_W-1:0]    req_op,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_arg1,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_arg2,
    output logic [NUM_REQ-1:0]         done,
    output logic                       err,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       busy,
    output logic                       ram_enable,
    output logic [OP_W-1:0]            ram_op,
    output logic [ADDR_W-1:0]          ram_arg1,
    output logic [ADDR_W-1:0]          ram_arg2,
    input  logic                       ram_finished,
    input  logic [DATA_W-1:0]          ram_out1
);

    import war_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Sized to hold TIMEOUT_CYC; the timeout leaves BUSY before any wrap.
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]    last_grant_q, last_grant_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                busy_q, busy_d;
    logic                ram_enable_q, ram_enable_d;
    logic [OP_W-1:0]     ram_op_q, ram_op_d;
    logic [ADDR_W-1:0]   ram_arg1_q, ram_arg1_d;
    logic [ADDR_W-1:0]   ram_arg2_q, ram_arg2_d;

    logic                pick_any;
    logic [IDX_W-1:0]    pick_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant_q),
        .any        (pick_any),
        .index      (pick_idx)
    );

    // State and output registers; reset wins even in the middle of an op.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            timer_q      <= '0;
            done_q       <= '0;
            err_q        <= 1'b0;
            rd_data_q    <= '0;
            busy_q       <= 1'b0;
            ram_enable_q <= 1'b0;
            ram_op_q     <= '0;
            ram_arg1_q   <= '0;
            ram_arg2_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rd_data_q    <= rd_data_d;
            busy_q       <= busy_d;
            ram_enable_q <= ram_enable_d;
            ram_op_q     <= ram_op_d;
            ram_arg1_q   <= ram_arg1_d;
            ram_arg2_q   <= ram_arg2_d;
        end
    end

    // Next-state logic: grant in IDLE, watch for finish/timeout in BUSY,
    // pulse done in RESP. done is computed one cycle early so it is registered.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        done_d       = '0;
        err_d        = err_q;
        rd_data_d    = rd_data_q;
        busy_d       = busy_q;
        ram_enable_d = ram_enable_q;
        ram_op_d     = ram_op_q;
        ram_arg1_d   = ram_arg1_q;
        ram_arg2_d   = ram_arg2_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d        = pick_idx;
                    ram_op_d     = req_op[int'(pick_idx)*OP_W +: OP_W];
                    ram_arg1_d   = req_arg1[int'(pick_idx)*ADDR_W +: ADDR_W];
                    ram_arg2_d   = req_arg2[int'(pick_idx)*ADDR_W +: ADDR_W];
                    ram_enable_d = 1'b1;
                    busy_d       = 1'b1;
                    timer_d      = '0;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (ram_finished) begin
                    rd_data_d    = ram_out1;
                    err_d        = 1'b0;
                    ram_enable_d = 1'b0;
                    last_grant_d = gnt_q;
                    done_d       = NUM_REQ'(1) << gnt_q;
                    state_d      = ST_RESP;
                end else if (timer_q == TMR_LAST) begin
                    rd_data_d    = '0;
                    err_d        = 1'b1;
                    ram_enable_d = 1'b0;
                    last_grant_d = gnt_q;
                    done_d       = NUM_REQ'(1) << gnt_q;
                    state_d      = ST_RESP;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RESP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign done       = done_q;
    assign err        = err_q;
    assign rd_data    = rd_data_q;
    assign busy       = busy_q;
    assign ram_enable = ram_enable_q;
    assign ram_op     = ram_op_q;
    assign ram_arg1   = ram_arg1_q;
    assign ram_arg2   = ram_arg2_q;

endmodule
